// File: rtl/vector_sync_pkg.sv
// rtl/vector_sync_pkg.sv - shared types and helpers for the vector synchronizer/filter
// Contents:
//   state_t    : filter FSM states (IDLE, SETTLE)
//   cnt_width(): bits needed for a stability counter running 0..n-1, never less than 1
package vector_sync_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/vector_sync_chain.sv
// rtl/vector_sync_chain.sv - multi-flop synchronizer chain for a data vector
// Parameters: DATA_WIDTH, SYNC_STAGE (>= 2), RESET_VAL
// Ports:
//   CLK  : destination clock
//   RSTn : asynchronous active-low reset, loads RESET_VAL into every stage
//   D    : asynchronous input vector
//   Q    : output of the last stage (synchronized sample)
module vector_sync_chain #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    SYNC_STAGE = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q
);

  if (SYNC_STAGE < 2) begin : g_bad_sync_stage
    $error("vector_sync_chain: SYNC_STAGE must be at least 2");
  end

  logic [DATA_WIDTH-1:0] stage [SYNC_STAGE];

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < SYNC_STAGE; i++) begin
        stage[i] <= RESET_VAL;
      end
    end else begin
      stage[0] <= D;
      for (int i = 1; i < SYNC_STAGE; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign Q = stage[SYNC_STAGE-1];

endmodule

// File: rtl/vector_sync_filter.sv
// rtl/vector_sync_filter.sv - synchronizes an async vector and commits it only after it is stable
// Optional feature macro: VECTOR_SYNC_EDGE_EN (adds RISE/FALL per-bit edge outputs)
// Parameters: DATA_WIDTH, SYNC_STAGE (>= 2), STABLE_CYCLES (>= 1), RESET_VAL
// Ports:
//   CLK    : destination clock
//   RSTn   : asynchronous active-low reset
//   D      : asynchronous input vector
//   FREEZE : holds off committing a new value while high
//   Q      : filtered, synchronized vector
//   CHG    : one-cycle pulse, high in the cycle Q shows a newly committed value
//   BUSY   : registered copy of "FSM is in SETTLE"
//   RISE   : (VECTOR_SYNC_EDGE_EN) bits that went 0->1 at the commit, else 0
//   FALL   : (VECTOR_SYNC_EDGE_EN) bits that went 1->0 at the commit, else 0
module vector_sync_filter
  import vector_sync_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    SYNC_STAGE    = 2,
  parameter int                    STABLE_CYCLES = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL     = '0
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  FREEZE,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  CHG,
`ifdef VECTOR_SYNC_EDGE_EN
  output logic [DATA_WIDTH-1:0] RISE,
  output logic [DATA_WIDTH-1:0] FALL,
`endif
  output logic                  BUSY
);

  if (STABLE_CYCLES < 1) begin : g_bad_stable_cycles
    $error("vector_sync_filter: STABLE_CYCLES must be at least 1");
  end

  localparam int              CW      = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [DATA_WIDTH-1:0] s;

  vector_sync_chain #(
    .DATA_WIDTH (DATA_WIDTH),
    .SYNC_STAGE (SYNC_STAGE),
    .RESET_VAL  (RESET_VAL)
  ) u_chain (
    .CLK  (CLK),
    .RSTn (RSTn),
    .D    (D),
    .Q    (s)
  );

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] cand, cand_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [DATA_WIDTH-1:0] q_n;
  logic                  chg_n;
`ifdef VECTOR_SYNC_EDGE_EN
  logic [DATA_WIDTH-1:0] rise_n, fall_n;
`endif

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= IDLE;
      cand  <= RESET_VAL;
      cnt   <= '0;
      Q     <= RESET_VAL;
      CHG   <= 1'b0;
      BUSY  <= 1'b0;
`ifdef VECTOR_SYNC_EDGE_EN
      RISE  <= '0;
      FALL  <= '0;
`endif
    end else begin
      state <= state_n;
      cand  <= cand_n;
      cnt   <= cnt_n;
      Q     <= q_n;
      CHG   <= chg_n;
      // BUSY lags the state by one cycle: it reflects where the FSM was, not where it is going.
      BUSY  <= (state == SETTLE);
`ifdef VECTOR_SYNC_EDGE_EN
      RISE  <= rise_n;
      FALL  <= fall_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    q_n     = Q;
    chg_n   = 1'b0;
`ifdef VECTOR_SYNC_EDGE_EN
    rise_n  = '0;
    fall_n  = '0;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (s != Q) begin
          cand_n  = s;
          state_n = SETTLE;
        end
      end
      SETTLE: begin
        if (s == Q) begin
          // Input fell back to the committed value: treat the excursion as a glitch.
          state_n = IDLE;
          cnt_n   = '0;
          cand_n  = Q;
        end else if (s != cand) begin
          cand_n = s;
          cnt_n  = '0;
        end else if (cnt != CNT_MAX) begin
          cnt_n = cnt + 1'b1;
        end else if (!FREEZE) begin
          q_n     = cand;
          chg_n   = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
`ifdef VECTOR_SYNC_EDGE_EN
          rise_n  = cand & ~Q;
          fall_n  = ~cand & Q;
`endif
        end
        // FREEZE high at the commit point: CNT stays saturated and we keep waiting.
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_vector_sync_filter.sv
// tb/tb_vector_sync_filter.sv - directed self-checking bench for vector_sync_filter
module tb_vector_sync_filter;

  logic        CLK;
  logic        RSTn;
  logic [31:0] D;
  logic        FREEZE;
  logic [31:0] Q;
  logic        CHG;
  logic        BUSY;
`ifdef VECTOR_SYNC_EDGE_EN
  logic [31:0] RISE;
  logic [31:0] FALL;
`endif

  int checks   = 0;
  int failures = 0;

  vector_sync_filter dut (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .D      (D),
    .FREEZE (FREEZE),
    .Q      (Q),
    .CHG    (CHG),
`ifdef VECTOR_SYNC_EDGE_EN
    .RISE   (RISE),
    .FALL   (FALL),
`endif
    .BUSY   (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One active edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  int chg_seen;
  int bad_q;

  initial begin
    RSTn   = 1'b0;
    D      = 32'h0;
    FREEZE = 1'b0;
    #12;
    check("reset_q",    Q,    32'h0);
    check("reset_chg",  {31'b0, CHG},  32'h0);
    check("reset_busy", {31'b0, BUSY}, 32'h0);
    tick();
    RSTn = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    // Two-cycle glitch to 1, then back to 0: rejected.
    D = 32'h1;
    tick();
    tick();
    D = 32'h0;
    chg_seen = 0;
    bad_q    = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (CHG) chg_seen++;
      if (Q !== 32'h0) bad_q++;
    end
    check("glitch_no_chg",  chg_seen, 0);
    check("glitch_q_held",  bad_q,    0);
    check("glitch_busy_lo", {31'b0, BUSY}, 32'h0);

    // Clean change: Q after exactly 7 edges, CHG at edge 7, BUSY after edges 4..7.
    D = 32'hA5A5_0001;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("lat_q_e%0d", k),    Q, (k >= 7) ? 32'hA5A5_0001 : 32'h0);
      check($sformatf("lat_chg_e%0d", k),  {31'b0, CHG},  (k == 7) ? 32'h1 : 32'h0);
      check($sformatf("lat_busy_e%0d", k), {31'b0, BUSY}, (k >= 4 && k <= 7) ? 32'h1 : 32'h0);
    end

    // 3 for two cycles, then 5: candidate restarts, single commit of 5 at edge 9.
    D = 32'h3;
    tick();
    tick();
    D = 32'h5;
    chg_seen = 0;
    for (int k = 3; k <= 12; k++) begin
      tick();
      if (CHG) chg_seen++;
      check($sformatf("restart_q_e%0d", k), Q, (k >= 9) ? 32'h5 : 32'hA5A5_0001);
    end
    check("restart_one_chg", chg_seen, 1);

    // FREEZE held over the commit point for 5 edges, released after edge 11.
    D      = 32'h77;
    FREEZE = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      check($sformatf("frz_q_e%0d", k),    Q, (k >= 12) ? 32'h77 : 32'h5);
      check($sformatf("frz_chg_e%0d", k),  {31'b0, CHG},  (k == 12) ? 32'h1 : 32'h0);
      check($sformatf("frz_busy_e%0d", k), {31'b0, BUSY}, (k >= 4 && k <= 12) ? 32'h1 : 32'h0);
      if (k == 11) FREEZE = 1'b0;
    end

    // Reset in SETTLE: outputs drop at once, then normal 7-edge resync to 0x99.
    D = 32'h99;
    for (int k = 1; k <= 4; k++) tick();
    RSTn = 1'b0;
    #1;
    check("midrst_q",    Q, 32'h0);
    check("midrst_chg",  {31'b0, CHG},  32'h0);
    check("midrst_busy", {31'b0, BUSY}, 32'h0);
    tick();
    RSTn = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("resync_q_e%0d", k),   Q, (k >= 7) ? 32'h99 : 32'h0);
      check($sformatf("resync_chg_e%0d", k), {31'b0, CHG}, (k == 7) ? 32'h1 : 32'h0);
    end

    // Reset in SETTLE toward the reset value: no CHG afterwards.
    D = 32'h0;
    for (int k = 1; k <= 4; k++) tick();
    RSTn = 1'b0;
    tick();
    RSTn = 1'b1;
    chg_seen = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (CHG) chg_seen++;
    end
    check("rstval_no_chg", chg_seen, 0);
    check("rstval_q",      Q, 32'h0);

`ifdef VECTOR_SYNC_EDGE_EN
    D = 32'hF0;
    for (int k = 1; k <= 8; k++) tick();
    check("edge_setup_q", Q, 32'hF0);
    D = 32'h3C;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("rise_e%0d", k), RISE, (k == 7) ? 32'h0C : 32'h0);
      check($sformatf("fall_e%0d", k), FALL, (k == 7) ? 32'hC0 : 32'h0);
    end
    check("edge_final_q", Q, 32'h3C);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
